// File: rtl/adder_share_sched_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : adder_share_sched_if                                            |
// | Brief    : Requester, response and shared-adder bundle for the scheduler.  |
// | Revision : 1.0                                                             |
// +-----------------------------------------------------------------------------+
interface adder_share_sched_if #(
    parameter int WIDTH = 24
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ci;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ci;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_co;

    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_ci;
    logic [3:0]       add_sum;
    logic             add_co;

    modport master (
        input  req0_valid, req0_a, req0_b, req0_ci,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ci,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_co,
        input  rsp_ready,
        output add_a, add_b, add_ci,
        input  add_sum, add_co
    );

    modport slave (
        output req0_valid, req0_a, req0_b, req0_ci,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ci,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_co,
        output rsp_ready,
        input  add_a, add_b, add_ci,
        output add_sum, add_co
    );
endinterface
`default_nettype wire

// File: rtl/adder_share_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : adder_share_sched                                               |
// | Brief    : Shares one external 4-bit adder between two requesters, adding  |
// |            WIDTH-bit operands one nibble per cycle. ADDER_SHARE_RR_EN      |
// |            selects round-robin arbitration (default: requester 0 wins).    |
// | Revision : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module adder_share_sched #(
    parameter int WIDTH = 24
) (
    input  wire logic          clk,
    input  wire logic          rst,
    adder_share_sched_if.master bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             id_q, id_d;
    logic [KW-1:0]    k_q, k_d;

    logic             w_grant;
    logic             w_req0_ready;
    logic             w_req1_ready;
    logic             w_rsp_valid;
    logic [3:0]       w_add_a;
    logic [3:0]       w_add_b;
    logic             w_add_ci;

`ifdef ADDER_SHARE_RR_EN
    logic last_q, last_d;

    // On contention the requester not served last wins; a lone requester always wins.
    assign w_grant = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

    always_comb begin
        last_d = last_q;
        if (w_req0_ready || w_req1_ready) begin
            last_d = w_req1_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign w_grant = ~bus.req0_valid & bus.req1_valid;
`endif

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        id_d         = id_q;
        k_d          = k_q;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_rsp_valid  = 1'b0;
        w_add_a      = 4'd0;
        w_add_b      = 4'd0;
        w_add_ci     = 1'b0;
        case (state_q)
            IDLE: begin
                w_req0_ready = bus.req0_valid & ~w_grant;
                w_req1_ready = bus.req1_valid &  w_grant;
                if (w_req0_ready) begin
                    a_d     = bus.req0_a;
                    b_d     = bus.req0_b;
                    carry_d = bus.req0_ci;
                    id_d    = 1'b0;
                    k_d     = '0;
                    state_d = RUN;
                end else if (w_req1_ready) begin
                    a_d     = bus.req1_a;
                    b_d     = bus.req1_b;
                    carry_d = bus.req1_ci;
                    id_d    = 1'b1;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                w_add_a  = a_q[{k_q, 2'b00} +: 4];
                w_add_b  = b_q[{k_q, 2'b00} +: 4];
                w_add_ci = carry_q;
                sum_d[{k_q, 2'b00} +: 4] = bus.add_sum;
                carry_d  = bus.add_co;
                k_d      = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            k_q     <= k_d;
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_co     = carry_q;
    assign bus.rsp_id     = id_q;
    assign bus.add_a      = w_add_a;
    assign bus.add_b      = w_add_b;
    assign bus.add_ci     = w_add_ci;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_adder_share_sched                                            |
// | Brief    : Directed bench with a transaction-level model of the scheduler. |
// | Revision : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module tb_adder_share_sched;
    localparam int WIDTH  = 24;
    localparam int NSLICE = WIDTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_share_sched_if #(.WIDTH(WIDTH)) bus ();

    adder_share_sched #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared ripple adder stand-in.
    always_comb begin
        {bus.add_co, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_ci};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Transaction model: one outstanding job, accepted at edge m_t-1's successor.
    bit     m_pend = 1'b0;
    bit     m_last = 1'b1;
    bit     m_id   = 1'b0;
    longint m_a    = 0;
    longint m_b    = 0;
    longint m_ci   = 0;
    int     cyc    = 0;
    int     m_t    = 0;
    bit     obs_ids[$];

    function automatic bit m_grant(input bit v0, input bit v1);
`ifdef ADDER_SHARE_RR_EN
        return (v0 && v1) ? !m_last : v1;
`else
        return !v0 && v1;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0;
            m_last <= 1'b1;
        end else if (m_pend) begin
            if ((cyc - m_t) >= NSLICE && bus.rsp_ready) m_pend <= 1'b0;
        end else if (bus.req0_valid || bus.req1_valid) begin
            m_pend <= 1'b1;
            m_t    <= cyc + 1;
            m_id   <= m_grant(bus.req0_valid, bus.req1_valid);
            m_last <= m_grant(bus.req0_valid, bus.req1_valid);
            m_a    <= m_grant(bus.req0_valid, bus.req1_valid) ? longint'(bus.req1_a)  : longint'(bus.req0_a);
            m_b    <= m_grant(bus.req0_valid, bus.req1_valid) ? longint'(bus.req1_b)  : longint'(bus.req0_b);
            m_ci   <= m_grant(bus.req0_valid, bus.req1_valid) ? longint'(bus.req1_ci) : longint'(bus.req0_ci);
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        int     p;
        bit     ev, er;
        longint msk, total, ea, eb, eci;
        if (rst) begin
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_rsp_sum",   bus.rsp_sum,   0);
            check("rst_rsp_co",    bus.rsp_co,    0);
            check("rst_rsp_id",    bus.rsp_id,    0);
            check("rst_add_a",     bus.add_a,     0);
            check("rst_add_b",     bus.add_b,     0);
            check("rst_add_ci",    bus.add_ci,    0);
            check("rst_req0_ready", bus.req0_ready, 0);
            check("rst_req1_ready", bus.req1_ready, 0);
        end else begin
            p     = cyc - m_t;
            ev    = m_pend && (p >= NSLICE);
            er    = m_pend && (p < NSLICE);
            total = m_a + m_b + m_ci;
            ea = 0; eb = 0; eci = 0;
            if (er) begin
                msk = (longint'(1) << (4 * p)) - 1;
                ea  = (m_a >> (4 * p)) & 15;
                eb  = (m_b >> (4 * p)) & 15;
                eci = ((m_a & msk) + (m_b & msk) + m_ci) >> (4 * p);
            end
            check("req0_ready", bus.req0_ready,
                  !m_pend && bus.req0_valid && !m_grant(bus.req0_valid, bus.req1_valid));
            check("req1_ready", bus.req1_ready,
                  !m_pend && bus.req1_valid && m_grant(bus.req0_valid, bus.req1_valid));
            check("rsp_valid", bus.rsp_valid, ev);
            check("add_a",  bus.add_a,  ea);
            check("add_b",  bus.add_b,  eb);
            check("add_ci", bus.add_ci, eci);
            if (ev) begin
                check("rsp_sum", bus.rsp_sum, total & 64'hFF_FFFF);
                check("rsp_co",  bus.rsp_co,  (total >> WIDTH) & 1);
                check("rsp_id",  bus.rsp_id,  m_id);
            end
            if (bus.rsp_valid && bus.rsp_ready) obs_ids.push_back(bus.rsp_id);
        end
    end

    task automatic drive(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit ci);
        if (!id) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_ci = ci;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_ci = ci;
        end
    endtask

    task automatic wait_accept(input bit id, output int waitn);
        waitn = 0;
        forever begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) break;
            waitn++;
            if (waitn > 60) begin
                timeout("accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!id) bus.req0_valid = 1'b0;
        else     bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [WIDTH-1:0] s, output bit co, output bit id,
                            output int lat, output int ones);
        lat  = 0;
        ones = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
            if (bus.add_ci) ones++;
            if (lat > 60) begin
                timeout("response");
                break;
            end
        end
        s  = bus.rsp_sum;
        co = bus.rsp_co;
        id = bus.rsp_id;
        if (bus.rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] s, hold_s;
        bit               co, rid, hold_co, hold_id;
        int               w, lat, ones, acc;
        bit               exp_ids [4];

        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ci = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ci = 0;
        bus.rsp_ready  = 1;

        repeat (2) @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_sum",   bus.rsp_sum,   0);
        check("reset_req0_ready", bus.req0_ready, 0);
        @(posedge clk);
        #1;

        // 1 + 1
        drive(0, 24'h000001, 24'h000001, 0);
        wait_accept(0, w);
        wait_rsp(s, co, rid, lat, ones);
        check("t1_sum", s, 24'h000002);
        check("t1_co", co, 0);
        check("t1_id", rid, 0);
        check("t1_latency", lat, 7);

        // Carry ripples through every slice
        drive(1, 24'hFFFFFF, 24'h000000, 1);
        wait_accept(1, w);
        wait_rsp(s, co, rid, lat, ones);
        check("t2_sum", s, 24'h000000);
        check("t2_co", co, 1);
        check("t2_id", rid, 1);
        check("t2_ci_slices", ones, 6);

        drive(0, 24'h123456, 24'h654321, 0);
        wait_accept(0, w);
        wait_rsp(s, co, rid, lat, ones);
        check("t3_sum", s, 24'h777777);
        check("t3_co", co, 0);

        drive(0, 24'h800000, 24'h800000, 0);
        wait_accept(0, w);
        wait_rsp(s, co, rid, lat, ones);
        check("t4_sum", s, 24'h000000);
        check("t4_co", co, 1);

        // Back-pressure in DONE with a competing requester waiting
        bus.rsp_ready = 0;
        drive(0, 24'hABCDEF, 24'h111111, 1);
        wait_accept(0, w);
        wait_rsp(hold_s, hold_co, hold_id, lat, ones);
        check("stall_sum", hold_s, 24'hBCDF01);
        check("stall_co", hold_co, 0);
        @(posedge clk);
        #1;
        drive(1, 24'h000FFF, 24'h000001, 0);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_hold_sum", bus.rsp_sum, hold_s);
            check("stall_hold_co", bus.rsp_co, hold_co);
            check("stall_hold_id", bus.rsp_id, hold_id);
            check("stall_req0_ready", bus.req0_ready, 0);
            check("stall_req1_ready", bus.req1_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1;
        wait_accept(1, w);
        check("stall_idle_after", w, 1);
        wait_rsp(s, co, rid, lat, ones);
        check("t5_sum", s, 24'h001000);
        check("t5_id", rid, 1);

        // Reset in the middle of RUN at slice 3
        drive(0, 24'h5A5A5A, 24'h1F2F3F, 0);
        wait_accept(0, w);
        repeat (3) @(posedge clk);
        #1;
        check("k3_add_a", bus.add_a, 4'h5);
        check("k3_add_b", bus.add_b, 4'h2);
        check("k3_add_ci", bus.add_ci, 1);
        #1 rst = 1;
        #1;
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_add_a", bus.add_a, 0);
        check("arst_add_b", bus.add_b, 0);
        check("arst_add_ci", bus.add_ci, 0);
        @(posedge clk);
        #3 rst = 0;
        drive(1, 24'h000FFF, 24'h000001, 0);
        wait_accept(1, w);
        check("post_rst_first_edge", w, 0);
        wait_rsp(s, co, rid, lat, ones);
        check("t6_sum", s, 24'h001000);
        check("t6_co", co, 0);
        check("t6_id", rid, 1);

        // Both requesters valid for four transactions
`ifdef ADDER_SHARE_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        obs_ids.delete();
        drive(0, 24'h000010, 24'h000020, 0);
        drive(1, 24'h000100, 24'h000200, 1);
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) acc++;
            if (acc == 4) break;
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        if (acc != 4) timeout("contention_accepts");
        for (int i = 0; i < 100 && obs_ids.size() < 4; i++) @(posedge clk);
        if (obs_ids.size() < 4) begin
            timeout("contention_responses");
        end else begin
            for (int i = 0; i < 4; i++) check($sformatf("contention_id%0d", i), obs_ids[i], exp_ids[i]);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adder_share_sched.md
# adder_share_sched

Scheduler that shares a single 4-bit ripple adder between two requesters and uses it to add WIDTH-bit operands one nibble per cycle.

- Arbitrates between requester 0 and requester 1, latches the granted operands and runs WIDTH/4 slices through the external adder, least significant slice first.
- Registers the carry between slices and returns the full sum and carry-out on a valid/ready response port.
- Sits between the operand producers and the gate-level ripple_adder netlist. The adder stays a pure combinational instance; this block owns all sequencing.

## Interface
Parameters:
- WIDTH, 24, operand width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived slice count; not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_ci  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_ci  same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester index of the result.
- rsp_sum  output  WIDTH  sum.
- rsp_co  output  1  final carry-out.
- add_a, add_b  output  4  slice operands to the shared adder.
- add_ci  output  1  slice carry-in to the shared adder.
- add_sum  input  4  adder sum, combinational from add_a/add_b/add_ci.
- add_co  input  1  adder carry-out.

## Operation
- State machine with three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - Arbitrate among the valid requesters.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational and at most one ready is high.
  - On reqN_valid && reqN_ready: latch a, b and id; load the carry register with ci; set slice counter k=0; go to RUN.
- RUN, per cycle:
  - add_a = a_reg[4k+3:4k], add_b = b_reg[4k+3:4k], add_ci = carry_reg.
  - At the edge: sum_reg[4k+3:4k] <= add_sum, carry_reg <= add_co, k <= k+1.
  - After slice k=NSLICE-1: go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum=sum_reg, rsp_co=carry_reg, rsp_id=id_reg.
  - On rsp_ready: go to IDLE.
- Outside RUN: add_a=0, add_b=0, add_ci=0.
- Arithmetic: {rsp_co, rsp_sum} = a + b + ci, modulo 2^(WIDTH+1). No overflow flagging.
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_co=0, add_a/add_b/add_ci=0. The round-robin pointer resets to "last granted = 1".
- rst asserted mid-RUN or in DONE:
  - All registers clear immediately and the in-flight result is discarded.
  - Operands are not replayed; the requester treats its prior handshake as lost.
- Requesters hold operands only until their handshake. The block never reads req ports outside IDLE.

## Timing
- Accept edge T: handshake in IDLE.
- RUN occupies cycles T+1 .. T+NSLICE.
- rsp_valid rises at cycle T+NSLICE+1. For WIDTH=24 that is 7 cycles after acceptance.
- If rsp_ready is high in the first DONE cycle, the block is back in IDLE the next cycle, giving a minimum initiation interval of NSLICE+2 cycles.
- Simultaneous req0_valid and req1_valid: exactly one is granted and the other's ready stays low.
- rsp_ready held low: stay in DONE with rsp_* stable; both reqN_ready stay low.
- rsp_ready high outside DONE is ignored.

## Configuration
- ADDER_SHARE_RR_EN defined: round-robin arbitration.
  - On contention, grant the requester not granted last.
  - The pointer updates only on an accepted handshake.
- ADDER_SHARE_RR_EN undefined: fixed priority, requester 0 always wins contention. The pointer logic is compiled out.

## Test plan
- WIDTH=24, req0 a=0x000001 b=0x000001 ci=0, rsp_ready=1 -> rsp_sum=0x000002, rsp_co=0, rsp_id=0, rsp_valid exactly 7 cycles after accept.
- req1 a=0xFFFFFF b=0x000000 ci=1 -> rsp_sum=0x000000, rsp_co=1, rsp_id=1. Also check that add_ci=1 on every slice.
- req0 a=0x123456 b=0x654321 ci=0 -> 0x777777, co=0. Then a=0x800000 b=0x800000 ci=0 -> 0x000000, co=1.
- Both requesters valid continuously for 4 transactions:
  - With ADDER_SHARE_RR_EN, rsp_id sequence is 0,1,0,1.
  - Without it, the sequence is 0,0,0,0.
- rsp_ready low for 5 cycles in DONE -> rsp_valid=1 and rsp_sum/rsp_co/rsp_id unchanged; req0_ready=req1_ready=0 throughout; return to IDLE one cycle after rsp_ready rises.
- rst pulsed during RUN at k=3 -> asynchronously rsp_valid=0, add_a/add_b/add_ci=0. After release the block is in IDLE, the next request is accepted at the first edge, and its result is correct.
